dds_sweep_player: RTL

- Downstream consumer of the per-sweep 184-bit DDS profile bank, which holds up to 12 stored profile words indexed by sweep number.
- On a start command it steps through profiles 0..N-1 in order. For each profile it:
  - selects the profile word via an index port;
  - shifts the word serially into the DDS, MSB (bit 0) first;
  - pulses IO_UPDATE;
  - dwells for a programmed time.
- Sits between the profile bank and the DDS serial pins.

---
 rtl/dds_pkg.sv | 24 ++
 rtl/dds_serial_shifter.sv | 72 +++++++
 rtl/dds_sweep_player.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sweep player and its serial shifter.
package dds_pkg;

    localparam int unsigned WORD_W       = 184;
    localparam int unsigned NUM_PROFILES = 12;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned SCLK_DIV     = 4;
    localparam int unsigned UPD_W        = 4;
    localparam int unsigned DWELL_W      = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StUpdate,
        StDwell,
        StDone
    } state_e;

    function automatic logic [IDX_W-1:0] clamp_count(input logic [IDX_W-1:0] n);
        return (n > IDX_W'(NUM_PROFILES)) ? IDX_W'(NUM_PROFILES) : n;
    endfunction

endpackage

// File: rtl/dds_serial_shifter.sv
// Serialises one profile word MSB (bit 0) first; data changes on falling SCLK so the
// DDS samples on the rising edge. shift_done_o strobes on the final falling edge.
module dds_serial_shifter
    import dds_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [0:WORD_W-1] word_i,
    output logic              cs_n_o,
    output logic              sclk_o,
    output logic              sdio_o,
    output logic              shift_done_o
);

    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WORD_W);

    logic [0:WORD_W-1] shreg_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bit_q;
    logic              active_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              half_end;
    logic              last_fall;

    assign half_end  = active_q && (div_q == DIV_W'(SCLK_DIV - 1));
    assign last_fall = half_end && sclk_q && (bit_q == BIT_W'(WORD_W - 1));

    assign cs_n_o       = cs_n_q;
    assign sclk_o       = sclk_q;
    // Head of the shift register is the data pin; clearing it parks SDIO low.
    assign sdio_o       = shreg_q[0];
    assign shift_done_o = last_fall;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            shreg_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
        end else if (load_i) begin
            shreg_q  <= word_i;
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
            cs_n_q   <= 1'b0;
            sclk_q   <= 1'b0;
        end else if (half_end) begin
            div_q <= '0;
            if (!sclk_q) begin
                sclk_q <= 1'b1;
            end else if (last_fall) begin
                shreg_q  <= '0;
                active_q <= 1'b0;
                cs_n_q   <= 1'b1;
                sclk_q   <= 1'b0;
            end else begin
                sclk_q  <= 1'b0;
                shreg_q <= {shreg_q[1:WORD_W-1], 1'b0};
                bit_q   <= bit_q + 1'b1;
            end
        end else if (active_q) begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/dds_sweep_player.sv
// Plays stored DDS profiles 0..N-1 into the DDS serial port, strobing IO_UPDATE and
// dwelling after each; optional looping, abort and a one-cycle done pulse.
module dds_sweep_player
    import dds_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               loop_en,
    input  logic [IDX_W-1:0]   num_profiles,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [IDX_W-1:0]   profile_sel,
    input  logic [0:WORD_W-1]  profile_word,
    output logic               dds_cs_n,
    output logic               dds_sclk,
    output logic               dds_sdio,
    output logic               dds_io_update,
    output logic               busy,
    output logic               done
);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   n_q;
    logic [IDX_W-1:0]   sel_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               upd_q;
    logic               busy_q;
    logic               done_q;

    logic [IDX_W-1:0]   start_n;
    logic               load;
    logic               shift_done;
    logic               step_now;
    state_e             step_state;
    logic [IDX_W-1:0]   step_idx;

    assign start_n = clamp_count(num_profiles);
    // Second FETCH cycle: the bank output has had a full cycle to settle.
    assign load    = (state_q == StFetch) && (cnt_q != '0);

    assign step_now = ((state_q == StUpdate) && (cnt_q == DWELL_W'(UPD_W - 1)) && (dwell_q == '0))
                   || ((state_q == StDwell) && (cnt_q == dwell_q - 1'b1));

    always_comb begin
        step_idx   = '0;
        step_state = StDone;
        if (idx_q != n_q - 1'b1) begin
            step_idx   = idx_q + 1'b1;
            step_state = StFetch;
        end else if (loop_en) begin
            step_state = StFetch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q <= StIdle;
            idx_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            if (reset) begin
                n_q     <= '0;
                dwell_q <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        n_q     <= start_n;
                        dwell_q <= dwell_cycles;
                        idx_q   <= '0;
                        sel_q   <= '0;
                        cnt_q   <= '0;
                        if (start_n != '0) begin
                            state_q <= StFetch;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (cnt_q == '0) cnt_q <= DWELL_W'(1);
                    else             state_q <= StShift;
                end
                StShift: begin
                    if (shift_done) begin
                        state_q <= StUpdate;
                        upd_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StUpdate: begin
                    if (cnt_q == DWELL_W'(UPD_W - 1)) begin
                        upd_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StDwell;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDwell: cnt_q <= cnt_q + 1'b1;
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase

            // Shared exit from UPDATE/DWELL; overrides the per-state updates above.
            if (step_now) begin
                cnt_q   <= '0;
                state_q <= step_state;
                done_q  <= (step_state == StDone);
                if (step_state == StFetch) begin
                    idx_q <= step_idx;
                    sel_q <= step_idx;
                end
            end
        end
    end

    assign profile_sel   = sel_q;
    assign dds_io_update = upd_q;
    assign busy          = busy_q;
    assign done          = done_q;

    dds_serial_shifter u_shifter (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (abort),
        .load_i       (load),
        .word_i       (profile_word),
        .cs_n_o       (dds_cs_n),
        .sclk_o       (dds_sclk),
        .sdio_o       (dds_sdio),
        .shift_done_o (shift_done)
    );

endmodule
